// File: rtl/adder_tree_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_tree_pkg
// Description : Shared types for the adder-tree block family (resolver FSM).
// Revision    : 1.0 - initial release
// ============================================================================
package adder_tree_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } resolve_state_t;

    // Counter width that stays legal when only one value is needed.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa_chunk_add.sv
`default_nettype none
// ============================================================================
// Module      : csa_chunk_add
// Description : Combinational CHUNK_W-bit adder with carry-in and carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_chunk_add #(
    parameter int CHUNK_W = 4
) (
    input  logic [CHUNK_W-1:0] i_a,
    input  logic [CHUNK_W-1:0] i_b,
    input  logic               i_cin,
    output logic [CHUNK_W-1:0] o_sum,
    output logic               o_cout
);

    logic [CHUNK_W:0] w_total;

    assign w_total         = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK_W{1'b0}}, i_cin};
    assign {o_cout, o_sum} = w_total;

endmodule
`default_nettype wire

// File: rtl/csa_resolve_serial.sv
`default_nettype none
// ============================================================================
// Module      : csa_resolve_serial
// Description : Resolves a carry-save pair into a binary sum, CHUNK_W bits
//               per cycle, behind valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_resolve_serial
    import adder_tree_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int CHUNK_W  = 4,
    localparam int N_CHUNK  = DATA_W / CHUNK_W,
    localparam int O_DATA_W = DATA_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    output logic                i_ready,
    input  logic [DATA_W-1:0]   i_sum,
    input  logic [DATA_W-1:0]   i_carry,
    output logic                o_valid,
    input  logic                o_ready,
    output logic [O_DATA_W-1:0] o_data
);

    localparam int                 c_IDX_W    = idx_width(N_CHUNK);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N_CHUNK - 1);

    generate
        if ((DATA_W % CHUNK_W) != 0) begin : g_bad_width
            $error("csa_resolve_serial: DATA_W must be a multiple of CHUNK_W");
        end
    endgenerate

    resolve_state_t      r_state;
    resolve_state_t      w_state_next;
    logic [c_IDX_W-1:0]  r_idx;
    logic                r_chunk_carry;
    logic [DATA_W-1:0]   r_sum;
    logic [DATA_W-1:0]   r_carry;
    logic [DATA_W-1:0]   r_res;
    logic [DATA_W-1:0]   w_res_next;
    logic [CHUNK_W-1:0]  w_chunk_sum;
    logic                w_chunk_cout;
    logic                w_last;

    assign w_last = (r_idx == c_LAST_IDX);

    // Operands shift right each BUSY cycle so the active chunk is always the
    // low slice; resolved chunks enter the result from the top.
    csa_chunk_add #(
        .CHUNK_W (CHUNK_W)
    ) u_chunk_add (
        .i_a    (r_sum[CHUNK_W-1:0]),
        .i_b    (r_carry[CHUNK_W-1:0]),
        .i_cin  (r_chunk_carry),
        .o_sum  (w_chunk_sum),
        .o_cout (w_chunk_cout)
    );

    assign w_res_next = (r_res >> CHUNK_W) | (DATA_W'(w_chunk_sum) << (DATA_W - CHUNK_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_valid) w_state_next = BUSY;
            BUSY:    if (w_last)  w_state_next = DONE;
            DONE:    if (o_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        i_ready = (r_state == IDLE);
        o_valid = (r_state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx         <= '0;
            r_chunk_carry <= 1'b0;
            r_sum         <= '0;
            r_carry       <= '0;
            r_res         <= '0;
            o_data        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_sum         <= i_sum;
                        r_carry       <= i_carry;
                        r_idx         <= '0;
                        r_chunk_carry <= 1'b0;
                    end
                end
                BUSY: begin
                    r_sum         <= r_sum >> CHUNK_W;
                    r_carry       <= r_carry >> CHUNK_W;
                    r_chunk_carry <= w_chunk_cout;
                    r_res         <= w_res_next;
                    if (w_last) begin
                        r_idx  <= '0;
                        o_data <= {w_chunk_cout, w_res_next};
                    end else begin
                        r_idx  <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csa_resolve_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_csa_resolve_serial
// Description : Scoreboard bench for csa_resolve_serial (DATA_W=8, CHUNK_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_csa_resolve_serial;

    localparam int c_DATA_W  = 8;
    localparam int c_CHUNK_W = 4;
    localparam int c_N_CHUNK = 2;

    logic                clk     = 1'b0;
    logic                rst     = 1'b1;
    logic                i_valid = 1'b0;
    logic                o_ready = 1'b1;
    logic [c_DATA_W-1:0] i_sum   = '0;
    logic [c_DATA_W-1:0] i_carry = '0;
    logic                i_ready;
    logic                o_valid;
    logic [c_DATA_W:0]   o_data;

    typedef struct {
        logic [c_DATA_W:0] data;
        int                acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    logic prev_v  = 1'b0;
    logic hs_prev = 1'b0;

    csa_resolve_serial #(
        .DATA_W  (c_DATA_W),
        .CHUNK_W (c_CHUNK_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_sum   (i_sum),
        .i_carry (i_carry),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send(input logic [7:0] s, input logic [7:0] c, input logic [8:0] exp_sum);
        int waited = 0;
        i_valid = 1'b1;
        i_sum   = s;
        i_carry = c;
        while (!i_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!i_ready) check("accept_timeout", 0, 1);
        else          sb.push_back('{data: exp_sum, acc: cyc + 1});
        @(negedge clk);
        i_valid = 1'b0;
        i_sum   = 8'($urandom);
        i_carry = 8'($urandom);
    endtask

    task automatic drain();
        int waited = 0;
        while ((sb.size() != 0 || o_valid) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("drain_left", sb.size(), 0);
    endtask

    // Monitor: compares whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        if (rst) begin
            prev_v  = 1'b0;
            hs_prev = 1'b0;
        end else begin
            if (hs_prev) begin
                check("post_hs_o_valid", int'(o_valid), 0);
                check("post_hs_i_ready", int'(i_ready), 1);
            end
            hs_prev = 1'b0;
            if (o_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_o_valid", 1, 0);
                end else begin
                    mon_e = sb[0];
                    if (!prev_v) check("latency", cyc - mon_e.acc, c_N_CHUNK);
                    check("o_data", int'(o_data), int'(mon_e.data));
                    check("i_ready_in_done", int'(i_ready), 0);
                    if (o_ready) begin
                        void'(sb.pop_front());
                        hs_prev = 1'b1;
                    end
                end
            end
            prev_v = o_valid;
        end
    end

    logic [7:0] vec_s [7] = '{8'hFF, 8'h00, 8'hAA, 8'h0F, 8'hF0, 8'h7F, 8'h08};
    logic [7:0] vec_c [7] = '{8'h01, 8'h00, 8'h55, 8'h01, 8'h10, 8'h7F, 8'h08};
    logic [8:0] vec_r [7] = '{9'h100, 9'h000, 9'h0FF, 9'h010, 9'h100, 9'h0FE, 9'h010};

    initial begin
        logic [7:0] rs;
        logic [7:0] rc;
        int         waited;

        repeat (3) @(negedge clk);
        check("rst_o_valid", int'(o_valid), 0);
        check("rst_o_data",  int'(o_data),  0);
        check("rst_i_ready", int'(i_ready), 1);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) send(vec_s[k], vec_c[k], vec_r[k]);
        drain();

        // Back-pressure hold
        o_ready = 1'b0;
        send(8'hFF, 8'hFF, 9'h1FE);
        waited = 0;
        while (!o_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_o_valid", int'(o_valid), 1);
            check("bp_o_data",  int'(o_data),  9'h1FE);
            check("bp_i_ready", int'(i_ready), 0);
            @(negedge clk);
        end
        o_ready = 1'b1;
        drain();

        // Reset while in flight
        send(8'h80, 8'h80, 9'h100);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_i_ready", int'(i_ready), 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_no_valid", int'(o_valid), 0);
        end
        send(8'h01, 8'h02, 9'h003);
        drain();

        // Streaming: inputs change every cycle, including mid-BUSY
        i_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            rs      = 8'($urandom);
            rc      = 8'($urandom);
            i_sum   = rs;
            i_carry = rc;
            if (i_ready) sb.push_back('{data: {1'b0, rs} + {1'b0, rc}, acc: cyc + 1});
            @(negedge clk);
        end
        i_valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
